mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Byte-serial memory sequencer sharing the 8-bit bus between instruction fetch and load/store.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise LS always wins over IF.
module mem_arbiter (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clr_in,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [1:0]  ls_len,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, RD, WR, IO_WAIT, IO_GAP} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic [2:0]  len_q, len_d;
  logic [2:0]  k_q, k_d;
  logic        pend_q, pend_d;
  logic        ownerLs_q, ownerLs_d;
  logic        lastLs_q, lastLs_d;
  logic        ifDone_q, ifDone_d;
  logic        lsDone_q, lsDone_d;
  logic [31:0] ifData_q, ifData_d;
  logic [31:0] lsData_q, lsData_d;
  logic        grantLs, grantIf;
  logic        ioAddr;
  logic [1:0]  kPrev;

  function automatic logic [2:0] lenBytes(input logic [1:0] l);
    case (l)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  assign ioAddr = (addr_q[17:16] == 2'b11);
  // pend_q marks that byte k-1 was addressed last cycle and its data is on mem_din now
  assign kPrev  = k_q[1:0] - 2'd1;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rbuf_q    <= '0;
      len_q     <= '0;
      k_q       <= '0;
      pend_q    <= 1'b0;
      ownerLs_q <= 1'b0;
      lastLs_q  <= 1'b1;
      ifDone_q  <= 1'b0;
      lsDone_q  <= 1'b0;
      ifData_q  <= '0;
      lsData_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rbuf_q    <= rbuf_d;
      len_q     <= len_d;
      k_q       <= k_d;
      pend_q    <= pend_d;
      ownerLs_q <= ownerLs_d;
      lastLs_q  <= lastLs_d;
      ifDone_q  <= ifDone_d;
      lsDone_q  <= lsDone_d;
      ifData_q  <= ifData_d;
      lsData_q  <= lsData_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rbuf_d    = rbuf_q;
    len_d     = len_q;
    k_d       = k_q;
    pend_d    = pend_q;
    ownerLs_d = ownerLs_q;
    lastLs_d  = lastLs_q;
    ifDone_d  = ifDone_q;
    lsDone_d  = lsDone_q;
    ifData_d  = ifData_q;
    lsData_d  = lsData_q;
    grantLs   = 1'b0;
    grantIf   = 1'b0;
    if (rdy_in) begin
      ifDone_d = 1'b0;
      lsDone_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          // No grant while a done pulse is out: the requester has not yet dropped req
          if (!clr_in && !ifDone_q && !lsDone_q) begin
`ifdef MEM_ARB_RR_EN
            grantLs = ls_req && (!if_req || !lastLs_q);
`else
            grantLs = ls_req;
`endif
            grantIf = if_req && !grantLs;
            k_d     = '0;
            pend_d  = 1'b0;
            rbuf_d  = '0;
            if (grantLs) begin
              addr_d    = ls_addr;
              wdata_d   = ls_wdata;
              len_d     = lenBytes(ls_len);
              ownerLs_d = 1'b1;
              lastLs_d  = 1'b1;
              if (!ls_wr)
                state_d = RD;
              else if (ls_addr[17:16] == 2'b11 && io_buffer_full)
                state_d = IO_WAIT;
              else
                state_d = WR;
            end else if (grantIf) begin
              addr_d    = if_addr;
              len_d     = 3'd4;
              ownerLs_d = 1'b0;
              lastLs_d  = 1'b0;
              state_d   = RD;
            end
          end
        end
        RD: begin
          // IO-space loads have side effects, so only they survive a flush
          if (clr_in && !(ownerLs_q && ioAddr)) begin
            state_d = IDLE;
            pend_d  = 1'b0;
          end else begin
            if (pend_q)
              rbuf_d[{kPrev, 3'b000} +: 8] = mem_din;
            if (k_q == len_q) begin
              state_d = IDLE;
              pend_d  = 1'b0;
              if (ownerLs_q) begin
                lsDone_d = 1'b1;
                lsData_d = rbuf_d;
              end else begin
                ifDone_d = 1'b1;
                ifData_d = rbuf_d;
              end
            end else begin
              k_d    = k_q + 3'd1;
              pend_d = 1'b1;
            end
          end
        end
        WR: begin
          if (k_q == len_q - 3'd1) begin
            lsDone_d = 1'b1;
            k_d      = '0;
            state_d  = ioAddr ? IO_GAP : IDLE;
          end else begin
            k_d = k_q + 3'd1;
          end
        end
        IO_WAIT: begin
          if (!io_buffer_full)
            state_d = WR;
        end
        IO_GAP: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // While paused, keep re-addressing the byte whose data is due so it is valid on resume
  always_comb begin
    mem_wr   = 1'b0;
    mem_a    = '0;
    mem_dout = '0;
    unique case (state_q)
      RD: begin
        if (!rdy_in && pend_q)
          mem_a = addr_q + {30'b0, kPrev};
        else if (k_q != len_q)
          mem_a = addr_q + {29'b0, k_q};
      end
      WR: begin
        mem_wr   = rdy_in;
        mem_a    = addr_q + {29'b0, k_q};
        mem_dout = wdata_q[{k_q[1:0], 3'b000} +: 8];
      end
      default: ;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign if_done  = ifDone_q;
  assign if_data  = ifData_q;
  assign ls_done  = lsDone_q;
  assign ls_rdata = lsData_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table vectors, hand sequences and randomized traffic
// against a byte-array reference memory. Honours MEM_ARB_RR_EN for the arbitration expectations.
module tb_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clr_in, io_buffer_full;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        if_req;
  logic [31:0] if_addr, if_data;
  logic        if_done;
  logic        ls_req, ls_wr, ls_done;
  logic [1:0]  ls_len;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        busy;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    bit          isLs;
    bit          wr;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expData;
    int          expCycles;
  } vector_t;

  vector_t     vecTable [0:9];
  logic [7:0]  refMem [0:65535];
  logic [7:0]  memArr [0:65535];
  bit          memWritten [0:65535];

  mem_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
    .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .if_req(if_req), .if_addr(if_addr),
    .if_done(if_done), .if_data(if_data), .ls_req(ls_req), .ls_wr(ls_wr),
    .ls_len(ls_len), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_done(ls_done),
    .ls_rdata(ls_rdata), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] defaultByte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Memory with one-cycle read latency; unwritten locations hold a fixed pattern
  always @(posedge clk_in) begin
    mem_din <= memWritten[mem_a[15:0]] ? memArr[mem_a[15:0]] : defaultByte(mem_a[15:0]);
    if (mem_wr) begin
      memArr[mem_a[15:0]]     <= mem_dout;
      memWritten[mem_a[15:0]] <= 1'b1;
    end
  end

  function automatic int lenBytes(input logic [1:0] l);
    return (l == 2'd0) ? 1 : (l == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a, input int n);
    logic [31:0] v;
    logic [31:0] ai;
    v = '0;
    for (int i = 0; i < n; i++) begin
      ai = a + 32'(i);
      v  = v | ({24'b0, refMem[ai[15:0]]} << (8 * i));
    end
    return v;
  endfunction

  function automatic void refWrite(input logic [31:0] a, input int n, input logic [31:0] d);
    logic [31:0] ai;
    for (int i = 0; i < n; i++) begin
      ai = a + 32'(i);
      refMem[ai[15:0]] = d[8*i +: 8];
    end
  endfunction

  function automatic vector_t mkVec(input bit isLs, input bit wr, input logic [1:0] len,
                                    input logic [31:0] addr, input logic [31:0] wdata,
                                    input logic [31:0] expData, input int expCycles);
    vector_t v;
    v.isLs = isLs; v.wr = wr; v.len = len; v.addr = addr;
    v.wdata = wdata; v.expData = expData; v.expCycles = expCycles;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected)
      passCount++;
    else
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Issues one request, checks the bus byte by byte and waits (bounded) for its done pulse
  task automatic applyStimulus(input bit isLs, input bit wr, input logic [1:0] len,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] data, output int cycles);
    int          n;
    bit          got;
    bit          isStore;
    logic [31:0] expA;
    n       = isLs ? lenBytes(len) : 4;
    isStore = isLs && wr;
    if (isLs) begin
      ls_wr = wr; ls_len = len; ls_addr = addr; ls_wdata = wdata; ls_req = 1'b1;
    end else begin
      if_addr = addr; if_req = 1'b1;
    end
    got = 1'b0; cycles = 0; data = '0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk_in);
      if (c <= n) begin
        expA = addr + 32'(c - 1);
        checkOutput("bus_addr", mem_a, expA);
        checkOutput("bus_wr", {31'b0, mem_wr}, {31'b0, isStore});
        if (isStore)
          checkOutput("bus_dout", {24'b0, mem_dout}, {24'b0, wdata[8*(c-1) +: 8]});
      end
      if (isLs ? ls_done : if_done) begin
        got = 1'b1; cycles = c; data = isLs ? ls_rdata : if_data;
      end
    end
    if_req = 1'b0; ls_req = 1'b0;
    checkOutput("done_seen", {31'b0, got}, 32'd1);
    @(negedge clk_in);
  endtask

  logic [31:0] rdData;
  int          rdCycles;
  int          order [0:3];
  int          nDone, doneCyc, wrEarly, pauseBad;
  bit          sawDone, isLsR, wrR;
  logic [1:0]  lenR;
  logic [31:0] addrR, wdataR;
  int          kindR, nR;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 65536; i++) refMem[i] = defaultByte(16'(i));

    vecTable[0] = mkVec(1, 1, 2'd3, 32'h0000_1000, 32'h0000_0513, 32'h0, 5);
    vecTable[1] = mkVec(0, 0, 2'd3, 32'h0000_1000, 32'h0, 32'h0000_0513, 6);
    vecTable[2] = mkVec(1, 1, 2'd1, 32'h0000_0200, 32'h0000_BEEF, 32'h0, 3);
    vecTable[3] = mkVec(1, 0, 2'd1, 32'h0000_0200, 32'h0, 32'h0000_BEEF, 4);
    vecTable[4] = mkVec(1, 0, 2'd0, 32'h0000_0201, 32'h0, 32'h0000_00BE, 3);
    vecTable[5] = mkVec(1, 1, 2'd3, 32'hFFFF_FFFE, 32'hCAFE_F00D, 32'h0, 5);
    vecTable[6] = mkVec(1, 0, 2'd3, 32'hFFFF_FFFE, 32'h0, 32'hCAFE_F00D, 6);
    vecTable[7] = mkVec(1, 0, 2'd2, 32'h0000_1000, 32'h0, 32'h0000_0513, 6);
    vecTable[8] = mkVec(1, 1, 2'd0, 32'h0000_0300, 32'h1234_56AB, 32'h0, 2);
    vecTable[9] = mkVec(1, 0, 2'd0, 32'h0000_0300, 32'h0, 32'h0000_00AB, 3);

    rst_in = 1'b1; rdy_in = 1'b1; clr_in = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_wr = 1'b0; ls_len = '0;
    ls_addr = '0; ls_wdata = '0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_if_done", {31'b0, if_done}, 32'd0);
    checkOutput("rst_ls_done", {31'b0, ls_done}, 32'd0);
    checkOutput("rst_if_data", if_data, 32'd0);
    checkOutput("rst_ls_rdata", ls_rdata, 32'd0);
    checkOutput("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
    checkOutput("rst_mem_a", mem_a, 32'd0);
    checkOutput("rst_mem_dout", {24'b0, mem_dout}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecTable[i].isLs, vecTable[i].wr, vecTable[i].len, vecTable[i].addr,
                    vecTable[i].wdata, rdData, rdCycles);
      checkOutput($sformatf("vec%0d_cycles", i), 32'(rdCycles), 32'(vecTable[i].expCycles));
      if (vecTable[i].wr)
        refWrite(vecTable[i].addr, lenBytes(vecTable[i].len), vecTable[i].wdata);
      else
        checkOutput($sformatf("vec%0d_data", i), rdData, vecTable[i].expData);
    end

    // Both requesting continuously; the previous grant was LS, as it is out of reset
    if_addr = 32'h1000; ls_wr = 1'b0; ls_len = 2'd0; ls_addr = 32'h200;
    if_req = 1'b1; ls_req = 1'b1;
    nDone = 0;
    for (int i = 0; i < 4; i++) order[i] = 2;
    for (int c = 0; c < 100 && nDone < 4; c++) begin
      @(negedge clk_in);
      if (if_done && nDone < 4) begin order[nDone] = 0; nDone++; end
      if (ls_done && nDone < 4) begin order[nDone] = 1; nDone++; end
    end
    if_req = 1'b0; ls_req = 1'b0;
    repeat (3) @(negedge clk_in);
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
      checkOutput($sformatf("arb_order%0d", i), 32'(order[i]), 32'(i % 2));
`else
      checkOutput($sformatf("arb_order%0d", i), 32'(order[i]), 32'd1);
`endif
    end

    // Flush during an IF read
    if_addr = 32'h1000; if_req = 1'b1; sawDone = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk_in);
      if (c == 3) begin clr_in = 1'b1; if_req = 1'b0; end
      if (c == 4) begin clr_in = 1'b0; checkOutput("clr_if_busy", {31'b0, busy}, 32'd0); end
      if (if_done) sawDone = 1'b1;
    end
    checkOutput("clr_if_no_done", {31'b0, sawDone}, 32'd0);

    // Flush during a store: the store still completes
    ls_wr = 1'b1; ls_len = 2'd3; ls_addr = 32'h400; ls_wdata = 32'h1122_3344; ls_req = 1'b1;
    doneCyc = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk_in);
      if (c == 3) clr_in = 1'b1;
      if (c == 4) clr_in = 1'b0;
      if (ls_done && doneCyc == 0) begin doneCyc = c; ls_req = 1'b0; end
    end
    ls_req = 1'b0;
    checkOutput("clr_ls_done_cycle", 32'(doneCyc), 32'd5);
    refWrite(32'h400, 4, 32'h1122_3344);
    applyStimulus(1, 0, 2'd3, 32'h400, 32'h0, rdData, rdCycles);
    checkOutput("clr_ls_readback", rdData, refRead(32'h400, 4));

    // IO store held off by a full UART buffer
    io_buffer_full = 1'b1; ls_wr = 1'b1; ls_len = 2'd0; ls_addr = 32'h0003_0000;
    ls_wdata = 32'h41; ls_req = 1'b1; wrEarly = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk_in);
      if (c == 5) io_buffer_full = 1'b0;
      if (c <= 5 && mem_wr) wrEarly++;
      if (c == 6) begin
        checkOutput("io_wr", {31'b0, mem_wr}, 32'd1);
        checkOutput("io_addr", mem_a, 32'h0003_0000);
        checkOutput("io_dout", {24'b0, mem_dout}, 32'h41);
      end
      if (c == 7) begin
        checkOutput("io_done", {31'b0, ls_done}, 32'd1);
        checkOutput("io_gap_wr", {31'b0, mem_wr}, 32'd0);
        checkOutput("io_gap_busy", {31'b0, busy}, 32'd1);
        ls_req = 1'b0;
      end
      if (c == 8) begin
        checkOutput("io_idle_busy", {31'b0, busy}, 32'd0);
        checkOutput("io_done_pulse", {31'b0, ls_done}, 32'd0);
      end
    end
    checkOutput("io_early_writes", 32'(wrEarly), 32'd0);
    refWrite(32'h0003_0000, 1, 32'h41);

    // LS read paused by rdy_in low in cycles 2-4
    ls_wr = 1'b0; ls_len = 2'd3; ls_addr = 32'h1000; ls_req = 1'b1;
    doneCyc = 0; pauseBad = 0; rdData = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk_in);
      if (c == 2) rdy_in = 1'b0;
      if (c == 5) rdy_in = 1'b1;
      if (c >= 2 && c <= 4 && (mem_wr || !busy || ls_done)) pauseBad++;
      if (ls_done && doneCyc == 0) begin doneCyc = c; rdData = ls_rdata; ls_req = 1'b0; end
    end
    ls_req = 1'b0;
    checkOutput("rdy_pause_state", 32'(pauseBad), 32'd0);
    checkOutput("rdy_done_cycle", 32'(doneCyc), 32'd9);
    checkOutput("rdy_data", rdData, refRead(32'h1000, 4));

    for (int t = 0; t < 40; t++) begin
      kindR  = int'($urandom_range(0, 2));
      isLsR  = (kindR != 0);
      wrR    = (kindR == 2);
      lenR   = 2'($urandom_range(0, 3));
      addrR  = 32'h2000 + 32'($urandom_range(0, 120));
      wdataR = $urandom;
      nR     = isLsR ? lenBytes(lenR) : 4;
      applyStimulus(isLsR, wrR, lenR, addrR, wdataR, rdData, rdCycles);
      if (wrR) begin
        checkOutput("rnd_wr_cycles", 32'(rdCycles), 32'(nR + 1));
        refWrite(addrR, nR, wdataR);
      end else begin
        checkOutput("rnd_rd_cycles", 32'(rdCycles), 32'(nR + 2));
        checkOutput("rnd_rd_data", rdData, refRead(addrR, nR));
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
